// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked multi-cycle adder/subtractor.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunk passes needed to cover the full operand width.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal geometry: chunk fits the width and divides it exactly.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_cla_chunk.sv
// CHUNK-bit combinational carry-lookahead adder. Exposes the carry into the
// MSB so the caller can derive signed overflow on the final chunk.
module cla_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] gen;
  logic [CHUNK-1:0] prop;
  logic [CHUNK:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Carry chain from generate/propagate terms.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign sum      = prop ^ carry[CHUNK-1:0];
  assign cout     = carry[CHUNK];
  assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CLA chunk is reused across NCHUNK clocks,
// with the inter-chunk carry held in a register.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_geometry
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK and CHUNK in 1..WIDTH");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IDXW-1:0]  idx;
  logic             last;
  logic [CHUNK-1:0] ch_a;
  logic [CHUNK-1:0] ch_b;
  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic             ch_msb_in;

  assign last = (idx == IDXW'(NCHUNK - 1));

  // Select the current chunk of each operand for the shared adder.
  always_comb begin
    ch_a = a_reg[int'(idx)*CHUNK +: CHUNK];
    ch_b = b_reg[int'(idx)*CHUNK +: CHUNK];
  end

  cla_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (ch_a),
    .b        (ch_b),
    .cin      (carry),
    .sum      (ch_sum),
    .cout     (ch_cout),
    .c_msb_in (ch_msb_in)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and per-chunk accumulation; subtraction is a + ~b + ~cin.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= sub ? ~b : b;
            carry   <= sub ? ~cin : cin;
            sum_reg <= '0;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_reg[int'(idx)*CHUNK +: CHUNK] <= ch_sum;
          carry <= ch_cout;
          if (last) begin
            cout_reg <= ch_cout;
            ovf_reg  <= ch_msb_in ^ ch_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and randomized checks of seq_chunk_adder at several geometries.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Default-geometry instance
  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  // Sweep instances share inputs
  logic        sw_valid = 1'b0, sw_oready = 1'b0, sw_cin = 1'b0, sw_sub = 1'b0;
  logic [31:0] sw_a = '0, sw_b = '0;
  logic        r0_ir, r0_ov, r0_c, r0_o;  logic [7:0]  r0_s;
  logic        r1_ir, r1_ov, r1_c, r1_o;  logic [7:0]  r1_s;
  logic        r2_ir, r2_ov, r2_c, r2_o;  logic [31:0] r2_s;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_8_8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r0_ir),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(r0_ov),
    .out_ready(sw_oready), .sum(r0_s), .cout(r0_c), .ovf(r0_o));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_8_1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r1_ir),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(r1_ov),
    .out_ready(sw_oready), .sum(r1_s), .cout(r1_c), .ovf(r1_o));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut_32_8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r2_ir),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(r2_ov),
    .out_ready(sw_oready), .sum(r2_s), .cout(r2_c), .ovf(r2_o));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference arithmetic in wide signed integers.
  function automatic void ref_model(input int w, input longint ua, input longint ub,
                                    input bit ci, input bit s, output longint rs,
                                    output bit rc, output bit ro);
    longint md, sa, sb, raw;
    md  = longint'(1) << w;
    sa  = (ua >= md / 2) ? ua - md : ua;
    sb  = (ub >= md / 2) ? ub - md : ub;
    raw = s ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
    ro  = (raw >= md / 2) || (raw < -(md / 2));
    rs  = ((raw % md) + md) % md;
    rc  = s ? (ua >= ub + longint'(ci)) : (ua + ub + longint'(ci) >= md);
  endfunction

  // Issue one op on the default instance, check latency, result and return to IDLE.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs, input logic [15:0] es,
                        input logic ec, input logic eo);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_ready_wait"}, 64'(n < 20), 64'd1);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = ~va; b = 16'hA5A5; cin = ~vc; sub = ~vs;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check({tag, "_latency"}, 64'(n), 64'd4);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_nvalid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    int lat0, lat1, lat2;
    longint es;
    bit ec, eo;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();

    // Directed vectors
    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1);

    // Backpressure: result held while out_ready=0, new operands ignored
    a = 16'h00F0; b = 16'h0F0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("bp_latency", 64'(n), 64'd4);
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_sum_hold", 64'(sum), 64'h1000);
      check("bp_cout_hold", 64'(cout), 64'd0);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_idle_sum", 64'(sum), 64'h1000);

    // Reset in the 2nd RUN cycle, then a clean op without stale carry
    a = 16'hFFFF; b = 16'h0001; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Geometry sweep against the reference model
    for (int t = 0; t < 200; t++) begin
      n = 0;
      while (!(r0_ir && r1_ir && r2_ir) && n < 20) begin tick(); n++; end
      check("sw_ready_wait", 64'(n < 20), 64'd1);
      sw_a = $urandom; sw_b = $urandom;
      if (t < 8) begin
        sw_a = (t[0]) ? 32'hFFFF_FFFF : 32'h7FFF_FF7F;
        sw_b = (t[1]) ? 32'h0000_0001 : 32'h8000_0080;
      end
      sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0; sw_a = ~sw_a; sw_b = ~sw_b;
      lat0 = 0; lat1 = 0; lat2 = 0;
      for (int c = 1; c <= 12; c++) begin
        tick();
        if (r0_ov && lat0 == 0) lat0 = c;
        if (r1_ov && lat1 == 0) lat1 = c;
        if (r2_ov && lat2 == 0) lat2 = c;
      end
      sw_a = ~sw_a; sw_b = ~sw_b;
      check("sw_lat_8_8", 64'(lat0), 64'd1);
      check("sw_lat_8_1", 64'(lat1), 64'd8);
      check("sw_lat_32_8", 64'(lat2), 64'd4);
      ref_model(8, longint'(sw_a[7:0]), longint'(sw_b[7:0]), sw_cin, sw_sub, es, ec, eo);
      check("sw_8_8", {55'd0, r0_c, r0_o, r0_s}, {55'd0, ec, eo, es[7:0]});
      check("sw_8_1", {55'd0, r1_c, r1_o, r1_s}, {55'd0, ec, eo, es[7:0]});
      ref_model(32, longint'(sw_a), longint'(sw_b), sw_cin, sw_sub, es, ec, eo);
      check("sw_32_8", {31'd0, r2_c, r2_o, r2_s}, {31'd0, ec, eo, es[31:0]});
      sw_oready = 1'b1;
      tick();
      sw_oready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
